// File: rtl/memory_group_ctrl.sv
`timescale 1ns/1ps
// memory_group_ctrl: two-port arbiter and setup/access/release strobe sequencer for the 8-bit memory_group.
// Build option MEMCTRL_RR_ARB_EN selects round-robin arbitration; when undefined, port 0 has fixed priority.
module memory_group_ctrl #(
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] rdata0,
   output logic [7:0] rdata1,
   output logic [7:0] mem_address,
   inout  wire  [7:0] mem_data,
   output logic       mem_chip_enable,
   output logic       mem_write_enable,
   output logic       mem_out_enable,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETUP   = 2'd1,
      S_ACCESS  = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES);
   localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYCLES);

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_phase;
   logic [3:0] w_phase_next;
   logic       r_port;
   logic       r_we;
   logic [7:0] r_addr;
   logic [7:0] r_wdata;
   logic [7:0] r_rdata0;
   logic [7:0] r_rdata1;
   logic       w_any_req;
   logic       w_grant;
   logic       w_winner;
   logic       w_phase_last;
   logic       w_sample;
   logic       w_drive;

   assign w_any_req    = req0 | req1;
   assign w_grant      = (r_state == S_IDLE) && w_any_req;
   assign w_phase_last = (r_phase == 4'd1);
   assign w_sample     = (r_state == S_ACCESS) && w_phase_last && !r_we;

`ifdef MEMCTRL_RR_ARB_EN
   // r_rr_ptr names the port that wins the next tie; it flips away from every winner.
   logic r_rr_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr <= 1'b0;
      end else if (w_grant) begin
         r_rr_ptr <= ~w_winner;
      end
   end

   assign w_winner = (req0 && req1) ? r_rr_ptr : req1;
`else
   assign w_winner = ~req0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_phase <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_phase <= w_phase_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_phase_next     = r_phase;
      busy             = 1'b1;
      mem_chip_enable  = 1'b1;
      mem_write_enable = 1'b0;
      mem_out_enable   = 1'b0;
      ack0             = 1'b0;
      ack1             = 1'b0;
      w_drive          = r_we;
      case (r_state)
         S_IDLE: begin
            busy            = 1'b0;
            mem_chip_enable = 1'b0;
            w_drive         = 1'b0;
            if (w_any_req) begin
               w_state_next = S_SETUP;
               w_phase_next = SETUP_LOAD;
            end
         end
         S_SETUP: begin
            if (w_phase_last) begin
               w_state_next = S_ACCESS;
               w_phase_next = ACCESS_LOAD;
            end else begin
               w_phase_next = r_phase - 4'd1;
            end
         end
         S_ACCESS: begin
            mem_write_enable = r_we;
            mem_out_enable   = ~r_we;
            if (w_phase_last) begin
               w_state_next = S_RELEASE;
               w_phase_next = 4'd1;
            end else begin
               w_phase_next = r_phase - 4'd1;
            end
         end
         S_RELEASE: begin
            ack0         = ~r_port;
            ack1         = r_port;
            w_state_next = S_IDLE;
            w_phase_next = 4'd0;
         end
         default: begin
            busy            = 1'b0;
            mem_chip_enable = 1'b0;
            w_drive         = 1'b0;
            w_state_next    = S_IDLE;
            w_phase_next    = 4'd0;
         end
      endcase
   end

   // Request fields are captured at grant so the requester may change them afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_port   <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= 8'h00;
         r_wdata  <= 8'h00;
         r_rdata0 <= 8'h00;
         r_rdata1 <= 8'h00;
      end else begin
         if (w_grant) begin
            r_port  <= w_winner;
            r_we    <= w_winner ? we1 : we0;
            r_addr  <= w_winner ? addr1 : addr0;
            r_wdata <= w_winner ? wdata1 : wdata0;
         end
         if (w_sample && !r_port) begin
            r_rdata0 <= mem_data;
         end
         if (w_sample && r_port) begin
            r_rdata1 <= mem_data;
         end
      end
   end

   assign mem_address = r_addr;
   assign rdata0      = r_rdata0;
   assign rdata1      = r_rdata1;
   assign mem_data    = w_drive ? r_wdata : 8'hzz;

endmodule

// File: tb/tb_memory_group_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for memory_group_ctrl: randomized two-port traffic against a behavioural memory and arbitration model.
module tb_memory_group_ctrl;

   localparam int SA = 1;
   localparam int AA = 2;
   localparam int SB = 2;
   localparam int AB = 3;
`ifdef MEMCTRL_RR_ARB_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       a_req0, a_req1, a_we0, a_we1;
   logic [7:0] a_addr0, a_addr1, a_wdata0, a_wdata1;
   logic       a_ack0, a_ack1;
   logic [7:0] a_rdata0, a_rdata1, a_mem_address;
   wire  [7:0] a_mem_data;
   logic       a_ce, a_we, a_oe, a_busy;
   logic [7:0] a_sram [256];

   logic       b_req0, b_req1, b_we0, b_we1;
   logic [7:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
   logic       b_ack0, b_ack1;
   logic [7:0] b_rdata0, b_rdata1, b_mem_address;
   wire  [7:0] b_mem_data;
   logic       b_ce, b_we, b_oe, b_busy;
   logic [7:0] b_sram [256];

   memory_group_ctrl u_dut_a (
      .clk(clk), .reset_n(rst_n),
      .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
      .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
      .ack0(a_ack0), .ack1(a_ack1), .rdata0(a_rdata0), .rdata1(a_rdata1),
      .mem_address(a_mem_address), .mem_data(a_mem_data),
      .mem_chip_enable(a_ce), .mem_write_enable(a_we), .mem_out_enable(a_oe),
      .busy(a_busy)
   );

   memory_group_ctrl #(.SETUP_CYCLES(SB), .ACCESS_CYCLES(AB)) u_dut_b (
      .clk(clk), .reset_n(rst_n),
      .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
      .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
      .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
      .mem_address(b_mem_address), .mem_data(b_mem_data),
      .mem_chip_enable(b_ce), .mem_write_enable(b_we), .mem_out_enable(b_oe),
      .busy(b_busy)
   );

   // Memories answer on OE; while A is idle the bench drives a marker so a stray DUT driver corrupts it.
   assign a_mem_data = a_oe ? a_sram[a_mem_address] : (!a_busy ? 8'hC3 : 8'hzz);
   assign b_mem_data = b_oe ? b_sram[b_mem_address] : 8'hzz;
   always @(posedge clk) if (a_we) a_sram[a_mem_address] <= a_mem_data;
   always @(posedge clk) if (b_we) b_sram[b_mem_address] <= b_mem_data;

   typedef struct { bit we; logic [7:0] addr; logic [7:0] data; } txn_t;
   typedef struct {
      bit port; bit we; logic [7:0] addr; logic [7:0] data;
      logic [7:0] rd; logic [7:0] r0; logic [7:0] r1;
   } exp_t;

   txn_t pq0[$];
   txn_t pq1[$];
   exp_t exp_q[$];
   logic [7:0] ref_mem [256];
   logic [7:0] m_r0, m_r1;
   bit         m_pref;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
      end
   endtask

   // Reference: serve the two request lists in the order the arbitration rule dictates.
   task automatic predict_round();
      int i0 = 0;
      int i1 = 0;
      while (i0 < pq0.size() || i1 < pq1.size()) begin
         bit   p;
         txn_t t;
         exp_t e;
         if (i0 < pq0.size() && i1 < pq1.size()) p = RR ? m_pref : 1'b0;
         else p = (i0 < pq0.size()) ? 1'b0 : 1'b1;
         if (p) begin t = pq1[i1]; i1++; end
         else begin t = pq0[i0]; i0++; end
         e.port = p; e.we = t.we; e.addr = t.addr; e.data = t.data; e.rd = 8'h00;
         if (t.we) ref_mem[t.addr] = t.data;
         else begin
            e.rd = ref_mem[t.addr];
            if (p) m_r1 = e.rd; else m_r0 = e.rd;
         end
         e.r0 = m_r0; e.r1 = m_r1;
         m_pref = ~p;
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_port(input bit p);
      txn_t list[$];
      if (p) list = pq1; else list = pq0;
      foreach (list[k]) begin
         int n   = 0;
         bit got = 1'b0;
         if (p) begin a_we1 = list[k].we; a_addr1 = list[k].addr; a_wdata1 = list[k].data; a_req1 = 1'b1; end
         else   begin a_we0 = list[k].we; a_addr0 = list[k].addr; a_wdata0 = list[k].data; a_req0 = 1'b1; end
         while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = p ? a_ack1 : a_ack0;
         end
         if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", p);
            break;
         end
         @(posedge clk); #1;
      end
      if (p) a_req1 = 1'b0; else a_req0 = 1'b0;
   endtask

   task automatic run_round();
      predict_round();
      @(posedge clk); #1;
      fork
         drive_port(1'b0);
         drive_port(1'b1);
      join
      repeat (2) @(posedge clk);
      #1;
      pq0.delete();
      pq1.delete();
   endtask

   function automatic txn_t mk(input bit we, input logic [7:0] addr, input logic [7:0] data);
      txn_t t;
      t.we = we; t.addr = addr; t.data = data;
      return t;
   endfunction

   // Monitor: bus/strobe invariants every cycle, and scoreboard pop on every ack.
   int mon_lat = 0, mon_wew = 0, mon_oew = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_lat = 0; mon_wew = 0; mon_oew = 0;
      end else begin
         chk("we_and_oe", {31'd0, a_we && a_oe}, 0);
         chk("strobe_without_ce", {31'd0, (a_we || a_oe) && !a_ce}, 0);
         chk("ce_vs_busy", {31'd0, a_ce}, {31'd0, a_busy});
         if (a_busy) mon_lat++; else mon_lat = 0;
         if (a_we) mon_wew++;
         else if (mon_wew != 0) begin chk("we_width", mon_wew, AA); mon_wew = 0; end
         if (a_oe) mon_oew++;
         else if (mon_oew != 0) begin chk("oe_width", mon_oew, AA); mon_oew = 0; end
         if (!a_busy) chk("idle_bus_released", {24'd0, a_mem_data}, 32'hC3);
         else if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL busy_without_request actual=busy required=idle");
         end else begin
            chk("mem_address", {24'd0, a_mem_address}, {24'd0, exp_q[0].addr});
            if (exp_q[0].we) begin
               chk("write_bus_data", {24'd0, a_mem_data}, {24'd0, exp_q[0].data});
               chk("oe_during_write", {31'd0, a_oe}, 0);
            end else begin
               chk("we_during_read", {31'd0, a_we}, 0);
               if (a_oe) chk("read_bus_data", {24'd0, a_mem_data}, {24'd0, exp_q[0].rd});
            end
         end
         if (a_ack0 || a_ack1) begin
            chk("ack_both", {31'd0, a_ack0 && a_ack1}, 0);
            chk("ack_latency", mon_lat, SA + AA + 1);
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_ack actual=ack0:%0d,ack1:%0d required=none", a_ack0, a_ack1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack_port", {31'd0, a_ack1}, {31'd0, e.port});
               chk("rdata0", {24'd0, a_rdata0}, {24'd0, e.r0});
               chk("rdata1", {24'd0, a_rdata1}, {24'd0, e.r1});
               $display("txn port=%0d we=%0d addr=%02h data=%02h rdata0=%02h rdata1=%02h",
                        e.port, e.we, e.addr, e.data, a_rdata0, a_rdata1);
            end
         end
      end
   end

   task automatic b_txn(input bit we, input logic [7:0] addr, input logic [7:0] data, input logic [7:0] exp_rd);
      int lat = 0, wcnt = 0, ocnt = 0, n = 0;
      bit got = 1'b0;
      @(posedge clk); #1;
      b_we0 = we; b_addr0 = addr; b_wdata0 = data; b_req0 = 1'b1;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (b_busy) lat++;
         if (b_we) wcnt++;
         if (b_oe) ocnt++;
         got = b_ack0;
      end
      chk("b_ack_latency", lat, SB + AB + 1);
      chk(we ? "b_we_width" : "b_oe_width", we ? wcnt : ocnt, AB);
      chk("b_other_strobe", we ? ocnt : wcnt, 0);
      if (!we) chk("b_rdata0", {24'd0, b_rdata0}, {24'd0, exp_rd});
      $display("txn b we=%0d addr=%02h data=%02h latency=%0d rdata0=%02h", we, addr, data, lat, b_rdata0);
      @(posedge clk); #1;
      b_req0 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      a_req0 = 0; a_req1 = 0; a_we0 = 0; a_we1 = 0;
      a_addr0 = 0; a_addr1 = 0; a_wdata0 = 0; a_wdata1 = 0;
      b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
      b_addr0 = 0; b_addr1 = 0; b_wdata0 = 0; b_wdata1 = 0;
      m_pref = 1'b0; m_r0 = 8'h00; m_r1 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, a_busy}, 0);
      chk("rst_ce", {31'd0, a_ce}, 0);
      chk("rst_we", {31'd0, a_we}, 0);
      chk("rst_oe", {31'd0, a_oe}, 0);
      chk("rst_ack", {30'd0, a_ack1, a_ack0}, 0);
      chk("rst_addr", {24'd0, a_mem_address}, 0);
      chk("rst_rdata", {16'd0, a_rdata1, a_rdata0}, 0);
      chk("rst_bus", {24'd0, a_mem_data}, 32'hC3);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) pq0.push_back(mk(1'b1, 8'h10 + 8'(i), 8'($urandom)));
      run_round();

      pq0.push_back(mk(1'b1, 8'h3C, 8'hA5));
      pq0.push_back(mk(1'b0, 8'h3C, 8'h5E));
      run_round();

      pq1.push_back(mk(1'b1, 8'h00, 8'hFF));
      pq1.push_back(mk(1'b1, 8'hFF, 8'h01));
      pq1.push_back(mk(1'b0, 8'h00, 8'h77));
      pq1.push_back(mk(1'b0, 8'hFF, 8'h88));
      run_round();

      for (int i = 0; i < 3; i++) begin
         pq0.push_back(mk(1'($urandom), 8'h10 + 8'($urandom_range(0, 7)), 8'($urandom)));
         pq1.push_back(mk(1'($urandom), 8'h10 + 8'($urandom_range(0, 7)), 8'($urandom)));
      end
      run_round();

      for (int r = 0; r < 20; r++) begin
         int n0 = $urandom_range(0, 3);
         int n1 = $urandom_range(0, 3);
         for (int i = 0; i < n0; i++) pq0.push_back(mk(1'($urandom), 8'h10 + 8'($urandom_range(0, 7)), 8'($urandom)));
         for (int i = 0; i < n1; i++) pq1.push_back(mk(1'($urandom), 8'h10 + 8'($urandom_range(0, 7)), 8'($urandom)));
         run_round();
      end

      // Abort a write in its ACCESS phase; address 0x77 is never read afterwards.
      begin
         int n = 0;
         pq0.push_back(mk(1'b1, 8'h77, 8'h99));
         predict_round();
         pq0.delete();
         @(posedge clk); #1;
         a_we0 = 1'b1; a_addr0 = 8'h77; a_wdata0 = 8'h99; a_req0 = 1'b1;
         while (!a_we && n < 20) begin @(negedge clk); n++; end
         chk("abort_reached_access", {31'd0, a_we}, 1);
         #2 rst_n = 1'b0;
         #1;
         chk("abort_we", {31'd0, a_we}, 0);
         chk("abort_ce", {31'd0, a_ce}, 0);
         chk("abort_busy", {31'd0, a_busy}, 0);
         chk("abort_ack", {30'd0, a_ack1, a_ack0}, 0);
         chk("abort_bus", {24'd0, a_mem_data}, 32'hC3);
         a_req0 = 1'b0;
         exp_q.delete();
         m_pref = 1'b0; m_r0 = 8'h00; m_r1 = 8'h00;
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         repeat (3) @(negedge clk);
         chk("abort_no_restart", {31'd0, a_busy}, 0);
      end

      pq0.push_back(mk(1'b0, 8'h3C, 8'h00));
      pq1.push_back(mk(1'b1, 8'h12, 8'h66));
      pq1.push_back(mk(1'b0, 8'h12, 8'h00));
      run_round();
      chk("scoreboard_drained", exp_q.size(), 0);

      b_txn(1'b1, 8'h3C, 8'h5A, 8'h00);
      b_txn(1'b0, 8'h3C, 8'h00, 8'h5A);
      b_txn(1'b1, 8'hC3, 8'h11, 8'h00);
      b_txn(1'b0, 8'hC3, 8'h00, 8'h11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
